// File: rtl/spi_bus_arbiter_ctrl_if.sv
// spi_bus_arbiter_ctrl_if: requester handshake (req/tx_data/cpol/cpha -> gnt/busy/done/done_id/rx_data) plus SPI pins (SCLK/MOSI/MISO/SS_n); slave = arbiter side
interface spi_bus_arbiter_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ*WIDTH-1:0] tx_data;
    logic cpol;
    logic cpha;
    logic [NREQ-1:0] gnt;
    logic busy;
    logic done;
    logic [$clog2(NREQ)-1:0] done_id;
    logic [WIDTH-1:0] rx_data;
    logic SCLK;
    logic MOSI;
    logic MISO;
    logic [NREQ-1:0] SS_n;
    modport master (
        output req, tx_data, cpol, cpha, MISO,
        input gnt, busy, done, done_id, rx_data, SCLK, MOSI, SS_n
    );
    modport slave (
        input req, tx_data, cpol, cpha, MISO,
        output gnt, busy, done, done_id, rx_data, SCLK, MOSI, SS_n
    );
endinterface

// File: rtl/spi_bus_arbiter_ctrl.sv
// spi_bus_arbiter_ctrl: round-robin SPI master shared by NREQ requesters; ports clk, reset_n (async active-low), bus (slave modport: handshake + SCLK/MOSI/MISO/SS_n)
module spi_bus_arbiter_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ = 4,
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic reset_n,
    spi_bus_arbiter_ctrl_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * WIDTH);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state, nstate;
    logic [DW-1:0] div;
    logic [EW-1:0] ecnt;
    logic [IW-1:0] ptr, id, win, done_id_q;
    logic [WIDTH-1:0] tx_sh, rx_sh, tx_sel, rx_q;
    logic cpol_q, cpha_q, phase, mosi, done_q;
    logic last_div, last_edge, sclk_edge, sample;
    assign last_div = div == DW'(CLK_DIV - 1);
    assign last_edge = ecnt == EW'(2 * WIDTH - 1);
    assign sclk_edge = state == XFER && last_div;
    assign sample = ecnt[0] == cpha_q;
    always_comb begin
        win = ptr;
        for (int k = NREQ; k >= 1; k--)
            if (bus.req[IW'((int'(ptr) + k) % NREQ)]) win = IW'((int'(ptr) + k) % NREQ);
        tx_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (win == IW'(i)) tx_sel = bus.tx_data[i*WIDTH +: WIDTH];
        nstate = state == IDLE  ? (|bus.req ? SETUP : IDLE) :
                 state == SETUP ? (last_div ? XFER : SETUP) :
                 state == XFER  ? (last_div && last_edge ? HOLD : XFER) :
                                  (last_div ? IDLE : HOLD);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            div <= '0;
            ecnt <= '0;
            ptr <= IW'(NREQ - 1);
            id <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            rx_q <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            phase <= 1'b0;
            mosi <= 1'b0;
            done_q <= 1'b0;
            done_id_q <= '0;
        end else begin
            state <= nstate;
            div <= state == IDLE || last_div ? '0 : div + 1'b1;
            done_q <= state == HOLD && last_div;
            if (state == HOLD && last_div) begin
                done_id_q <= id;
                rx_q <= rx_sh;
            end
            if (state == IDLE && |bus.req) begin
                id <= win;
                ptr <= win;
                tx_sh <= bus.cpha ? tx_sel : tx_sel << 1;
                if (!bus.cpha) mosi <= tx_sel[WIDTH-1];
                cpol_q <= bus.cpol;
                cpha_q <= bus.cpha;
                ecnt <= '0;
                phase <= 1'b0;
            end
            if (sclk_edge) begin
                ecnt <= last_edge ? '0 : ecnt + 1'b1;
                phase <= ~phase;
                if (sample) rx_sh <= {rx_sh[WIDTH-2:0], bus.MISO};
                else if (!last_edge) begin
                    mosi <= tx_sh[WIDTH-1];
                    tx_sh <= tx_sh << 1;
                end
            end
        end
    end
    assign bus.gnt = state == SETUP && div == '0 ? NREQ'(1) << id : '0;
    assign bus.SS_n = state == IDLE ? '1 : ~(NREQ'(1) << id);
    assign bus.busy = state != IDLE;
    assign bus.done = done_q;
    assign bus.done_id = done_id_q;
    assign bus.rx_data = rx_q;
    assign bus.SCLK = cpol_q ^ phase;
    assign bus.MOSI = mosi;
endmodule

// File: tb/tb_spi_bus_arbiter_ctrl.sv
// tb_spi_bus_arbiter_ctrl: directed bench for spi_bus_arbiter_ctrl at CLK_DIV=2 and CLK_DIV=1
module tb_spi_bus_arbiter_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sel = 1'b0;
    logic [3:0] req = '0;
    logic [31:0] tx = '0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic miso = 1'b0;
    int checks = 0;
    int failures = 0;
    spi_bus_arbiter_ctrl_if #(.WIDTH(8), .NREQ(4)) b2 ();
    spi_bus_arbiter_ctrl_if #(.WIDTH(8), .NREQ(4)) b1 ();
    spi_bus_arbiter_ctrl #(.WIDTH(8), .NREQ(4), .CLK_DIV(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
    spi_bus_arbiter_ctrl #(.WIDTH(8), .NREQ(4), .CLK_DIV(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
    assign b2.req = sel ? 4'b0 : req;
    assign b1.req = sel ? req : 4'b0;
    assign b2.tx_data = tx;
    assign b1.tx_data = tx;
    assign b2.cpol = cpol;
    assign b1.cpol = cpol;
    assign b2.cpha = cpha;
    assign b1.cpha = cpha;
    assign b2.MISO = miso;
    assign b1.MISO = miso;
    logic [3:0] m_gnt, m_ss;
    logic m_busy, m_done, m_sclk, m_mosi;
    logic [1:0] m_id;
    logic [7:0] m_rx;
    assign m_gnt = sel ? b1.gnt : b2.gnt;
    assign m_ss = sel ? b1.SS_n : b2.SS_n;
    assign m_busy = sel ? b1.busy : b2.busy;
    assign m_done = sel ? b1.done : b2.done;
    assign m_sclk = sel ? b1.SCLK : b2.SCLK;
    assign m_mosi = sel ? b1.MOSI : b2.MOSI;
    assign m_id = sel ? b1.done_id : b2.done_id;
    assign m_rx = sel ? b1.rx_data : b2.rx_data;
    always #5 clk = ~clk;
    int cyc, ss_low, ss_bad, gap_bad, edges, mosi_bad, gnt_n, gnt_cyc, done_n, done_cyc, mode;
    int gnt_log [8];
    logic [3:0] gnt_first, ss_val, prev_ss;
    logic [1:0] done_id_s;
    logic [7:0] rx_s, mosi_cap, slv;
    logic prev_sclk, prev_mosi, sclk_at_gnt, t_cpol, t_cpha, drop_on_gnt, re2;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic reset_mon();
        cyc = 0;
        ss_low = 0;
        ss_bad = 0;
        gap_bad = 0;
        edges = 0;
        mosi_bad = 0;
        gnt_n = 0;
        gnt_cyc = -1;
        done_n = 0;
        done_cyc = -1;
        gnt_first = '0;
        ss_val = '1;
        mosi_cap = '0;
        sclk_at_gnt = 1'bx;
        prev_ss = m_ss;
        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
    endtask
    task automatic tick();
        logic is_edge, smp;
        @(posedge clk);
        #1;
        cyc++;
        if (m_ss != 4'hF) begin
            ss_low++;
            ss_val = m_ss;
        end
        if ($countones(~m_ss) > 1) ss_bad++;
        if (prev_ss != 4'hF && m_ss != 4'hF && m_ss != prev_ss) gap_bad++;
        if (m_gnt != 4'b0) begin
            if (gnt_n == 0) begin
                gnt_cyc = cyc;
                gnt_first = m_gnt;
            end
            if (gnt_n < 8) gnt_log[gnt_n] = $clog2(m_gnt);
            gnt_n++;
            sclk_at_gnt = m_sclk;
            if (drop_on_gnt) req = req & ~m_gnt;
        end
        is_edge = m_sclk !== prev_sclk && prev_ss != 4'hF && m_ss != 4'hF;
        smp = (m_sclk !== t_cpol) ^ t_cpha;
        if (is_edge) begin
            edges++;
            if (smp) mosi_cap = {mosi_cap[6:0], m_mosi};
            else if (mode == 2) begin
                miso = slv[7];
                slv = {slv[6:0], 1'b0};
            end
        end
        if (m_mosi !== prev_mosi && m_gnt == 4'b0 && !(is_edge && !smp)) mosi_bad++;
        if (mode == 1) miso = m_mosi;
        if (m_done) begin
            done_n++;
            done_cyc = cyc;
            done_id_s = m_id;
            rx_s = m_rx;
            if (re2 && m_id == 2'd2) begin
                req[2] = 1'b1;
                re2 = 1'b0;
            end
        end
        prev_ss = m_ss;
        prev_sclk = m_sclk;
        prev_mosi = m_mosi;
    endtask
    task automatic run_until(input int ndone, input int budget, input string tag);
        int n = 0;
        while (done_n < ndone && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done_n, ndone);
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask
    initial begin
        mode = 0;
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        drop_on_gnt = 1'b1;
        re2 = 1'b0;
        slv = '0;
        done_id_s = '0;
        rx_s = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ss", m_ss, 4'hF);
        chk("rst_sclk", m_sclk, 1'b0);
        chk("rst_mosi", m_mosi, 1'b0);
        chk("rst_gnt", m_gnt, 4'h0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_done", m_done, 1'b0);
        chk("rst_done_id", m_id, 2'd0);
        chk("rst_rx", m_rx, 8'h00);
        reset_n = 1'b1;
        tx = 32'h0000_A500;
        mode = 1;
        reset_mon();
        req = 4'b0010;
        run_until(1, 60, "t1_done_seen");
        chk("t1_gnt_cyc", gnt_cyc, 1);
        chk("t1_gnt", gnt_first, 4'b0010);
        chk("t1_ss_val", ss_val, 4'b1101);
        chk("t1_ss_low", ss_low, 36);
        chk("t1_edges", edges, 16);
        chk("t1_sclk_idle", m_sclk, 1'b0);
        chk("t1_done_cyc", done_cyc, 37);
        chk("t1_done_id", done_id_s, 2'd1);
        chk("t1_rx", rx_s, 8'hA5);
        chk("t1_mosi_bits", mosi_cap, 8'hA5);
        chk("t1_mosi_timing", mosi_bad, 0);
        chk("t1_busy_end", m_busy, 1'b0);
        tx = 32'h0000_00C3;
        cpol = 1'b1;
        cpha = 1'b1;
        t_cpol = 1'b1;
        t_cpha = 1'b1;
        mode = 2;
        slv = 8'h3C;
        miso = 1'b0;
        reset_mon();
        req = 4'b0001;
        run_until(1, 60, "t2_done_seen");
        chk("t2_gnt", gnt_first, 4'b0001);
        chk("t2_sclk_at_gnt", sclk_at_gnt, 1'b1);
        chk("t2_edges", edges, 16);
        chk("t2_mosi_bits", mosi_cap, 8'hC3);
        chk("t2_mosi_on_fall", mosi_bad, 0);
        chk("t2_rx", rx_s, 8'h3C);
        chk("t2_done_id", done_id_s, 2'd0);
        chk("t2_done_cyc", done_cyc, 37);
        chk("t2_sclk_idle", m_sclk, 1'b1);
        cpol = 1'b0;
        cpha = 1'b0;
        t_cpol = 1'b0;
        t_cpha = 1'b0;
        mode = 0;
        miso = 1'b0;
        do_reset();
        reset_mon();
        req = 4'b1111;
        run_until(4, 200, "t3_done_seen");
        chk("t3_gnt_n", gnt_n, 4);
        chk("t3_order0", gnt_log[0], 0);
        chk("t3_order1", gnt_log[1], 1);
        chk("t3_order2", gnt_log[2], 2);
        chk("t3_order3", gnt_log[3], 3);
        chk("t3_ss_onehot", ss_bad, 0);
        chk("t3_ss_gap", gap_bad, 0);
        reset_mon();
        re2 = 1'b1;
        req = 4'b1100;
        run_until(3, 150, "t4_done_seen");
        chk("t4_order0", gnt_log[0], 2);
        chk("t4_order1", gnt_log[1], 3);
        chk("t4_order2", gnt_log[2], 2);
        chk("t4_ss_gap", gap_bad, 0);
        reset_mon();
        req = 4'b1000;
        repeat (20) tick();
        chk("t5_busy_mid", m_busy, 1'b1);
        chk("t5_ss_mid", m_ss, 4'b0111);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_ss", m_ss, 4'hF);
        chk("t5_rst_sclk", m_sclk, 1'b0);
        chk("t5_rst_busy", m_busy, 1'b0);
        chk("t5_rst_gnt", m_gnt, 4'h0);
        chk("t5_rst_mosi", m_mosi, 1'b0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("t5_no_done", done_n, 0);
        reset_mon();
        req = 4'b1001;
        run_until(1, 60, "t5_done_seen");
        chk("t5_first_gnt", gnt_first, 4'b0001);
        chk("t5_done_id", done_id_s, 2'd0);
        req = 4'b0000;
        sel = 1'b1;
        tx = 32'h0000_00FF;
        miso = 1'b0;
        #1;
        reset_mon();
        req = 4'b0001;
        repeat (6) tick();
        cpha = 1'b1;
        run_until(1, 40, "t6_done_seen");
        cpha = 1'b0;
        chk("t6_gnt_cyc", gnt_cyc, 1);
        chk("t6_ss_low", ss_low, 18);
        chk("t6_done_cyc", done_cyc, 19);
        chk("t6_rx", rx_s, 8'h00);
        chk("t6_edges", edges, 16);
        chk("t6_mosi_bits", mosi_cap, 8'hFF);
        chk("t6_done_id", done_id_s, 2'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
